// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, memory depth, reset PC and queue entry type for the fetch unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned COL   = 16;
    localparam int unsigned ROW_I = 15;
    localparam logic [COL-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        logic [COL-1:0] pc;
        logic [COL-1:0] instr;
    } fetch_entry_t;

    // Instructions are halfword aligned; the byte address wraps modulo 2^16.
    function automatic logic [COL-1:0] next_pc(input logic [COL-1:0] addr);
        return addr + COL'(2);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory, redirect and decoder-side signals of the fetch unit.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic [COL-1:0] pc;
    logic [COL-1:0] instr_in;
    logic           redirect_valid;
    logic [COL-1:0] redirect_pc;
    logic           ir_valid;
    logic           ir_ready;
    logic [COL-1:0] ir_instr;
    logic [COL-1:0] ir_pc;
    logic           fetch_fault;

    modport master (
        output pc, ir_valid, ir_instr, ir_pc, fetch_fault,
        input  instr_in, redirect_valid, redirect_pc, ir_ready
    );

    modport slave (
        input  pc, ir_valid, ir_instr, ir_pc, fetch_fault,
        output instr_in, redirect_valid, redirect_pc, ir_ready
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Circular fetch buffer with flush; head entry is kept in a register so it
// resets to zero and holds its last value while the buffer is empty.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]     head_ptr;
    logic [PTR_W-1:0]     tail_ptr;
    logic                 push_eff;
    logic                 pop_eff;
    logic [PTR_W-1:0]     head_after_pop;
    logic [CNT_W-1:0]     count_after_pop;

    always_comb begin
        push_eff        = push && !flush;
        pop_eff         = pop && !flush && (count != '0);
        head_after_pop  = pop_eff ? head_ptr + PTR_W'(1) : head_ptr;
        count_after_pop = count - CNT_W'(pop_eff);
    end

    // Storage carries no reset; only pointers, count and head register do.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[tail_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
            head_data <= '0;
        end else if (flush) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
        end else begin
            head_ptr <= head_after_pop;
            if (push_eff) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            count <= count_after_pop + CNT_W'(push_eff);
            // A full buffer pushing and popping writes the old head slot, not the new head.
            if (count_after_pop != '0) begin
                head_data <= mem[head_after_pop];
            end else if (push_eff) begin
                head_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC sequencing, redirect and range-fault handling in front of
// a small instruction queue feeding the decoder.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [COL-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned    QDEPTH     = 2,
    parameter int unsigned    IMEM_WORDS = ROW_I
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    logic [COL-1:0]   pc_q;
    logic             fault_q;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic             in_range;
    logic             pop_req;
    logic             pop;
    logic             fetch;

    always_comb begin
        in_range   = {1'b0, pc_q[4:1]} < 5'(IMEM_WORDS);
        pop_req    = (count != '0) && bus.ir_ready;
        pop        = pop_req && !bus.redirect_valid;
        fetch      = !bus.redirect_valid && !fault_q && in_range &&
                     ((count < CNT_W'(QDEPTH)) || pop_req);
        push_entry = '{pc: pc_q, instr: bus.instr_in};
    end

    // Redirect outranks fetch; an out-of-range pc latches the fault and holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q    <= {bus.redirect_pc[COL-1:1], 1'b0};
            fault_q <= 1'b0;
        end else if (fetch) begin
            pc_q    <= next_pc(pc_q);
        end else if (!in_range) begin
            fault_q <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .count     (count),
        .head_data (head)
    );

    assign bus.pc          = pc_q;
    assign bus.fetch_fault = fault_q;
    assign bus.ir_valid    = (count != '0);
    assign bus.ir_instr    = head.instr;
    assign bus.ir_pc       = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word k holds 16'h1000 + k.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = 16'h1000 + {12'h000, bus.pc[4:1]};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.ir_ready       = rdy;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.ir_ready       = 1'b0;

        // Asynchronous reset takes effect before the first clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_pc",       bus.pc,                  16'h0000);
        check("rst_valid",    16'(bus.ir_valid),       16'h0000);
        check("rst_fault",    16'(bus.fetch_fault),    16'h0000);
        check("rst_ir_instr", bus.ir_instr,            16'h0000);
        check("rst_ir_pc",    bus.ir_pc,               16'h0000);

        // Back-to-back streaming from reset release.
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("stream_valid", 16'(bus.ir_valid), 16'h0001);
            check("stream_ir_pc", bus.ir_pc,         16'(2 * k));
            check("stream_instr", bus.ir_instr,      16'(16'h1000 + k));
            check("stream_pc",    bus.pc,            16'(2 * k + 2));
        end

        // Stall: queue fills at two entries and pc stops at 4.
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) step();
        check("stall_valid", 16'(bus.ir_valid), 16'h0001);
        check("stall_pc",    bus.pc,            16'h0004);
        check("stall_ir_pc", bus.ir_pc,         16'h0000);
        check("stall_instr", bus.ir_instr,      16'h1000);
        bus.ir_ready = 1'b1;
        step();
        check("drain1_ir_pc", bus.ir_pc,    16'h0002);
        check("drain1_instr", bus.ir_instr, 16'h1001);
        check("drain1_pc",    bus.pc,       16'h0006);
        step();
        check("drain2_ir_pc", bus.ir_pc,    16'h0004);
        check("drain2_pc",    bus.pc,       16'h0008);
        step();
        check("drain3_ir_pc", bus.ir_pc,    16'h0006);

        // Redirect to an odd target while full; bit 0 is dropped.
        do_reset(1'b0);
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0009;
        #1;
        check("redir_preflush_valid", 16'(bus.ir_valid), 16'h0001);
        step();
        bus.redirect_valid = 1'b0;
        bus.ir_ready       = 1'b1;
        check("redir_valid", 16'(bus.ir_valid), 16'h0000);
        check("redir_pc",    bus.pc,            16'h0008);
        step();
        check("redir_ir_pc", bus.ir_pc,         16'h0008);
        check("redir_instr", bus.ir_instr,      16'h1004);
        check("redir_valid2", 16'(bus.ir_valid), 16'h0001);

        // Consecutive redirects: the last one wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0010;
        step();
        bus.redirect_pc    = 16'h0006;
        step();
        bus.redirect_valid = 1'b0;
        check("redir2_pc",    bus.pc,            16'h0006);
        check("redir2_valid", 16'(bus.ir_valid), 16'h0000);
        step();
        check("redir2_ir_pc", bus.ir_pc,    16'h0006);
        check("redir2_instr", bus.ir_instr, 16'h1003);

        // Run off the end of instruction memory.
        do_reset(1'b1);
        for (int k = 0; k < 15; k++) step();
        check("end_ir_pc", bus.ir_pc,               16'h001C);
        check("end_instr", bus.ir_instr,            16'h100E);
        check("end_pc",    bus.pc,                  16'h001E);
        check("end_fault_pre", 16'(bus.fetch_fault), 16'h0000);
        step();
        check("fault_set",   16'(bus.fetch_fault), 16'h0001);
        check("fault_valid", 16'(bus.ir_valid),    16'h0000);
        check("fault_ir_pc", bus.ir_pc,            16'h001C);
        step();
        step();
        check("fault_hold_pc",    bus.pc,                16'h001E);
        check("fault_hold_fault", 16'(bus.fetch_fault),  16'h0001);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0000;
        step();
        bus.redirect_valid = 1'b0;
        check("fault_clr",    16'(bus.fetch_fault), 16'h0000);
        check("fault_clr_pc", bus.pc,               16'h0000);
        step();
        check("refetch_valid", 16'(bus.ir_valid), 16'h0001);
        check("refetch_ir_pc", bus.ir_pc,         16'h0000);
        check("refetch_instr", bus.ir_instr,      16'h1000);

        // Reset mid-operation with a full queue and a pending redirect.
        do_reset(1'b0);
        step();
        step();
        check("pre_rst_pc", bus.pc, 16'h0004);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0014;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_pc",    bus.pc,               16'h0000);
        check("mid_rst_valid", 16'(bus.ir_valid),    16'h0000);
        check("mid_rst_instr", bus.ir_instr,         16'h0000);
        check("mid_rst_fault", 16'(bus.fetch_fault), 16'h0000);
        step();
        @(negedge clk);
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.ir_ready       = 1'b1;
        step();
        check("post_rst_ir_pc", bus.ir_pc,    16'h0000);
        check("post_rst_instr", bus.ir_instr, 16'h1000);
        check("post_rst_pc",    bus.pc,       16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter QDEPTH, default 2: fetch-queue entries; legal values are 2 or 4.
REQ-003 Parameter IMEM_WORDS, default `row_i (15): number of valid instruction-memory words.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 pc  out  16: byte address driven to instruction memory; memory word index = pc[4:1].
REQ-007 instr_in  in  16: instruction returned combinationally by memory for the current pc.
REQ-008 redirect_valid  in  1: branch/jump taken; replace the fetch stream.
REQ-009 redirect_pc  in  16: target byte address; bit 0 is ignored and forced to 0.
REQ-010 ir_valid  out  1: queue head is valid toward the decoder.
REQ-011 ir_ready  in  1: decoder accepts the head this cycle.
REQ-012 ir_instr  out  16: head instruction.
REQ-013 ir_pc  out  16: byte address of the head instruction.
REQ-014 fetch_fault  out  1: sticky flag; pc has reached or passed IMEM_WORDS.

Function
REQ-015 Pop: ir_valid && ir_ready removes the head at the clock edge; ir_valid is combinational from count != 0.
REQ-016 Fetch condition: !redirect_valid && !fetch_fault && pc[4:1] < IMEM_WORDS && (count < QDEPTH || pop).
REQ-017 Fetch action: enqueue {pc, instr_in} at the tail; pc <= pc + 2 (modulo 2^16, so 16'hFFFE wraps to 16'h0000).
REQ-018 A full queue with a simultaneous pop fetches that cycle; count is unchanged.
REQ-019 Redirect action: pc <= {redirect_pc[15:1],1'b0}; queue flushed (count <= 0); no enqueue that cycle; any pop is discarded.
REQ-020 Redirect has priority over fetch and pop; ir_valid is still driven from the pre-flush count during the redirect cycle.
REQ-021 Consecutive redirects: the last one wins; fetch resumes in the first cycle with redirect_valid = 0.
REQ-022 Out of range: pc[4:1] >= IMEM_WORDS sets fetch_fault and stops fetch; pc holds; entries already queued still drain.
REQ-023 fetch_fault clears only on reset or redirect; a redirect to an in-range target clears it in the same edge.
REQ-024 Empty queue: ir_instr and ir_pc hold their last values; their content is don't-care while ir_valid = 0.
REQ-025 Steady state with ir_ready held high: one instruction per cycle; first ir_valid appears 1 cycle after reset release.
REQ-026 Queue ordering is strictly FIFO; per-entry ir_pc equals the pc value at fetch time.

Reset
REQ-027 rst asserted: pc = RESET_PC, count = 0, ir_valid = 0, fetch_fault = 0, ir_instr = 16'h0000, ir_pc = 16'h0000, all immediately and without waiting for clk.
REQ-028 rst mid-operation discards all queued entries and any concurrent redirect.
REQ-029 Queue storage arrays need no reset; head/tail pointers and count are reset.

Structure
REQ-030 Word width (`col), IMEM depth (`row_i), and RESET_PC default are in the shared Parameter.v.
REQ-031 QDEPTH-entry circular buffer is a sub-module, fetch_queue (push, pop, flush, count, head data); PC/next-PC logic stays in the top level.

Verification
REQ-032 Reset release, ir_ready = 1, memory word k = 16'h1000 + k -> ir_pc 0,2,4,… and ir_instr 1000,1001,… back-to-back from cycle 1.
REQ-033 ir_ready = 0 for 5 cycles -> count saturates at 2, pc stops at 16'h0004; ir_ready = 1 -> entries pc 0 then 2 emerge in order, no loss or duplication.
REQ-034 Redirect to 16'h0009 while queue full -> next cycle ir_valid = 0, pc = 16'h0008; following cycle ir_pc = 16'h0008.
REQ-035 Free-run past word 14 -> last ir_pc = 16'h001C, fetch_fault = 1, pc holds 16'h001E; redirect to 0 clears fault and refetches word 0.
REQ-036 Assert rst while queue holds 2 entries and redirect_valid = 1 -> same-cycle pc = RESET_PC, ir_valid = 0; after release, fetch restarts at RESET_PC.
